// File: rtl/uart_rx_if.sv
// Bridge-side bundle of the UART receive front end: byte holding register,
// status flags, FSM state for observation, and the bridge's consume pulse.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 overrun;
  logic [1:0]           state_dbg;

  // Handshake: rx_valid stays high while rx_data holds an unconsumed byte;
  // the bridge consumes it with a one-cycle rx_ack pulse, which is ignored
  // while rx_valid is low.
  modport master (
    input  rx_ack,
    output rx_data, rx_valid, rx_busy, frame_err, overrun, state_dbg
  );

  modport slave (
    output rx_ack,
    input  rx_data, rx_valid, rx_busy, frame_err, overrun, state_dbg
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling FSM and a
// one-entry holding register with framing-error and overrun reporting.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 20,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk_in,
  input  logic      sys_rstn,
  input  logic      uart_rxd,
  uart_rx_if.master bus
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 ferr_q;
  logic                 overrun_q;
  logic                 rxd_s;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync_q    <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], uart_rxd};
      ferr_q <= 1'b0;

      // A plain consume; a delivery on the same edge overrides this below.
      if (bus.rx_ack && valid_q) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state  <= START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxd_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_FULL) begin
            shreg[idx] <= rxd_s;
            cnt        <= '0;
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt    <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
            if (rxd_s) begin
              if (!valid_q) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
              end else if (bus.rx_ack) begin
                data_q    <= shreg;
                valid_q   <= 1'b1;
                overrun_q <= overrun_q;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_busy   = busy_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = overrun_q;
  assign bus.state_dbg = state;

endmodule
